// File: rtl/truth_table_sweeper_if.sv
// Port bundle between the truth-table sweeper and the function block it checks.
// The master side is the sweeper. The slave side is the environment that owns start and s_in.
interface truth_table_sweeper_if;
  // start is a level request that is taken only while idle.
  // done is a one-cycle result-valid strobe, and the results stay stable until the next accepted start.
  logic       start;
  logic       s_in;
  logic       x;
  logic       y;
  logic       z;
  logic       busy;
  logic       done;
  logic       pass;
  logic [7:0] table_out;
  logic [3:0] err_count;
  logic [2:0] first_err;
  logic [1:0] dbg_state;

  modport master (
    input  start,
    input  s_in,
    output x,
    output y,
    output z,
    output busy,
    output done,
    output pass,
    output table_out,
    output err_count,
    output first_err,
    output dbg_state
  );

  modport slave (
    output start,
    output s_in,
    input  x,
    input  y,
    input  z,
    input  busy,
    input  done,
    input  pass,
    input  table_out,
    input  err_count,
    input  first_err,
    input  dbg_state
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// On-chip checker for a 3-input combinational block.
// It walks {x,y,z} through 000..111, samples s_in after SETTLE cycles and compares the table it builds against EXPECTED.
module truth_table_sweeper #(
  parameter int unsigned SETTLE   = 1,
  parameter logic [7:0]  EXPECTED = 8'h30
) (
  input  logic                    clk,
  input  logic                    reset,
  truth_table_sweeper_if.master   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_APPLY  = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  logic [1:0] state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] table_q, table_d;
  logic [3:0] err_q, err_d;
  logic [2:0] first_q, first_d;
  logic       pass_q, pass_d;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    table_d = table_q;
    err_d   = err_q;
    first_d = first_q;
    pass_d  = pass_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_APPLY;
          idx_d   = 3'd0;
          cnt_d   = SETTLE_M1;
          table_d = 8'h00;
          err_d   = 4'd0;
          first_d = 3'd0;
          pass_d  = 1'b0;
        end
      end

      ST_APPLY: begin
        // The counter is loaded with SETTLE-1, so APPLY lasts exactly SETTLE cycles.
        if (cnt_q == 4'd0) begin
          state_d = ST_SAMPLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      ST_SAMPLE: begin
        table_d[idx_q] = bus.s_in;
        if (bus.s_in != EXPECTED[idx_q]) begin
          err_d = err_q + 4'd1;
          if (err_q == 4'd0) begin
            first_d = idx_q;
          end
        end
        if (idx_q == 3'd7) begin
          // pass is registered on entry to DONE so that it appears together with done.
          state_d = ST_DONE;
          pass_d  = (err_d == 4'd0);
        end else begin
          state_d = ST_APPLY;
          idx_d   = idx_q + 3'd1;
          cnt_d   = SETTLE_M1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= 3'd0;
      cnt_q   <= 4'd0;
      table_q <= 8'h00;
      err_q   <= 4'd0;
      first_q <= 3'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      table_q <= table_d;
      err_q   <= err_d;
      first_q <= first_d;
      pass_q  <= pass_d;
    end
  end

  // The stimulus is the vector index itself, so it stays at 111 after a sweep.
  assign bus.x         = idx_q[2];
  assign bus.y         = idx_q[1];
  assign bus.z         = idx_q[0];
  assign bus.busy      = (state_q == ST_APPLY) || (state_q == ST_SAMPLE);
  assign bus.done      = (state_q == ST_DONE);
  assign bus.pass      = pass_q;
  assign bus.table_out = table_q;
  assign bus.err_count = err_q;
  assign bus.first_err = first_q;
  assign bus.dbg_state = state_q;

endmodule
